viterbi_ber_checker: RTL and testbench

// - Receive-side bit-error-rate monitor for the encoder -> channel -> Viterbi decoder chain.
// - Taps the transmitted bit stream (encoder input) and the recovered stream (decoder output).
// - Finds the unknown end-to-end latency automatically, locks to it, then counts compared bits and bit errors.
// - Counts only after lock; drops lock when the window error rate gets too high.

---
 rtl/viterbi_pkg.sv | 6 +
 rtl/sat_counter.sv | 15 +
 rtl/viterbi_ber_checker.sv | 85 ++++++++
 tb/tb_viterbi_ber_checker.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared state type and default sizing for the BER checker
package viterbi_pkg;
  typedef enum logic {SEARCH, LOCKED} ber_state_t;
  localparam int DEF_MAX_LAT = 64;
  localparam int LATW = $clog2(DEF_MAX_LAT);
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker: finds tx->rx latency, locks to it, then counts compares and bit errors
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int MAX_LAT  = DEF_MAX_LAT,
  parameter int SYNC_LEN = 32,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8,
  parameter int CTW      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_bit_i,
  input  logic                       tx_valid_i,
  input  logic                       rx_bit_i,
  input  logic                       rx_valid_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] lat_o,
  output logic [CTW-1:0]             bit_ct_o,
  output logic [CTW-1:0]             err_ct_o,
  output logic                       err_o
);
  localparam int LW = $clog2(MAX_LAT);
  localparam int FW = $clog2(MAX_LAT + 1);
  localparam int MW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WIN + 1);
  ber_state_t state, state_nx;
  logic [MAX_LAT-1:0] hist;
  logic [FW-1:0] fill;
  logic [LW-1:0] d;
  logic [MW-1:0] match_ct;
  logic [WW-1:0] win_ct, win_err;
  logic qual, mis, lock_go, win_end, drop;
  // a compare only counts once the history actually holds the tap it reads
  assign qual    = rx_valid_i && !clear_i && (int'(fill) > int'(d));
  assign mis     = qual && (rx_bit_i != hist[d]);
  assign lock_go = state == SEARCH && qual && !mis && int'(match_ct) == SYNC_LEN - 1;
  assign win_end = state == LOCKED && qual && int'(win_ct) == WIN - 1;
  assign drop    = win_end && (int'(win_err) + int'(mis) >= LOSS_THR);
  assign lat_o   = d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= SEARCH;
    else state <= state_nx;
  always_comb
    state_nx = clear_i ? SEARCH : lock_go ? LOCKED : drop ? SEARCH : state;
  always_comb
    locked_o = state == LOCKED;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist     <= '0;
      fill     <= '0;
      d        <= '0;
      match_ct <= '0;
      win_ct   <= '0;
      win_err  <= '0;
      err_o    <= 1'b0;
    end else begin
      if (tx_valid_i) begin
        hist <= {hist[MAX_LAT-2:0], tx_bit_i};
        if (int'(fill) < MAX_LAT) fill <= fill + 1'b1;
      end
      err_o <= state == LOCKED && mis;
      if (clear_i || drop) begin
        d        <= '0;
        match_ct <= '0;
        win_ct   <= '0;
        win_err  <= '0;
      end else if (state == SEARCH && qual) begin
        match_ct <= (mis || lock_go) ? '0 : match_ct + 1'b1;
        d        <= !mis ? d : (int'(d) == MAX_LAT - 1) ? '0 : d + 1'b1;
        win_ct   <= '0;
        win_err  <= '0;
      end else if (state == LOCKED && qual) begin
        win_ct  <= win_end ? '0 : win_ct + 1'b1;
        win_err <= win_end ? '0 : win_err + WW'(mis);
      end
    end
  sat_counter #(.W(CTW)) u_bit_ct (
    .clk(clk), .rst(rst), .inc(state == LOCKED && qual), .clr(clear_i), .q(bit_ct_o)
  );
  sat_counter #(.W(CTW)) u_err_ct (
    .clk(clk), .rst(rst), .inc(state == LOCKED && mis), .clr(clear_i), .q(err_ct_o)
  );
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker: phase table plus hand sequences, checked against a queue-based model
module tb_viterbi_ber_checker;
  localparam int MAX_LAT = 64, SYNC_LEN = 32, WIN = 64, LOSS_THR = 8;
  logic clk = 0, rst = 0;
  logic tx_bit = 0, tx_valid = 0, rx_bit = 0, rx_valid = 0, clear = 0;
  logic locked, locked4, err, err4;
  logic [5:0] lat, lat4;
  logic [31:0] bit_ct, err_ct;
  logic [3:0] bit_ct4, err_ct4;
  int checks = 0, errors = 0;
  int hq[$];
  int m_d, m_match, m_wc, m_we;
  bit m_lock, m_err;
  longint m_bit, m_errc;
  bit tx_log[20000];
  int t = 0;
  typedef struct {
    int delay; int cycles; int pct; int mode; bit clr_first;
    int exp_locked; int exp_lat; longint exp_dbit; longint exp_derr; int exp_drop;
  } row_t;
  row_t rows[6];

  viterbi_ber_checker u_dut (
    .clk(clk), .rst(rst), .tx_bit_i(tx_bit), .tx_valid_i(tx_valid), .rx_bit_i(rx_bit),
    .rx_valid_i(rx_valid), .clear_i(clear), .locked_o(locked), .lat_o(lat),
    .bit_ct_o(bit_ct), .err_ct_o(err_ct), .err_o(err)
  );
  viterbi_ber_checker #(.CTW(4)) u_dut4 (
    .clk(clk), .rst(rst), .tx_bit_i(tx_bit), .tx_valid_i(tx_valid), .rx_bit_i(rx_bit),
    .rx_valid_i(rx_valid), .clear_i(clear), .locked_o(locked4), .lat_o(lat4),
    .bit_ct_o(bit_ct4), .err_ct_o(err_ct4), .err_o(err4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_d = 0; m_match = 0; m_wc = 0; m_we = 0;
    m_lock = 0; m_err = 0; m_bit = 0; m_errc = 0;
  endtask

  // next model state from the inputs currently applied
  task automatic model_step();
    bit qual, mis;
    m_err = 0;
    qual = rx_valid && !clear && (hq.size() > m_d);
    mis = qual && (rx_bit != hq[m_d][0]);
    if (clear) begin
      m_lock = 0; m_d = 0; m_match = 0; m_bit = 0; m_errc = 0; m_wc = 0; m_we = 0;
    end else if (qual && !m_lock) begin
      if (mis) begin
        m_match = 0;
        m_d = (m_d + 1) % MAX_LAT;
      end else begin
        m_match++;
        if (m_match == SYNC_LEN) begin m_lock = 1; m_wc = 0; m_we = 0; end
      end
    end else if (qual) begin
      if (m_bit < 64'hFFFF_FFFF) m_bit++;
      if (mis) begin
        if (m_errc < 64'hFFFF_FFFF) m_errc++;
        m_err = 1;
        m_we++;
      end
      m_wc++;
      if (m_wc == WIN) begin
        if (m_we >= LOSS_THR) begin m_lock = 0; m_d = 0; m_match = 0; end
        m_wc = 0; m_we = 0;
      end
    end
    if (tx_valid) begin
      hq.push_front(int'(tx_bit));
      if (hq.size() > MAX_LAT) void'(hq.pop_back());
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("locked", longint'(locked), longint'(m_lock));
    chk("lat", longint'(lat), longint'(m_d));
    chk("bit_ct", longint'(bit_ct), m_bit);
    chk("err_ct", longint'(err_ct), m_errc);
    chk("err_o", longint'(err), longint'(m_err));
    chk("locked4", longint'(locked4), longint'(m_lock));
    chk("bit_ct4", longint'(bit_ct4), m_bit > 15 ? 15 : m_bit);
    chk("err_ct4", longint'(err_ct4), m_errc > 15 ? 15 : m_errc);
  endtask

  task automatic run_phase(input row_t r);
    longint b0, e0;
    int pulses;
    bit dropped;
    b0 = bit_ct; e0 = err_ct; pulses = 0; dropped = 0;
    for (int i = 0; i < r.cycles; i++) begin
      tx_bit = 1'($urandom);
      tx_valid = 1;
      tx_log[t] = tx_bit;
      rx_valid = $urandom_range(99) < r.pct;
      rx_bit = (t >= r.delay) ? tx_log[t - r.delay] : 1'($urandom);
      if ((r.mode == 1 && i % 200 == 100) || (r.mode == 2 && i >= 10 && i < 26)) begin
        rx_bit = ~rx_bit;
        rx_valid = 1;
      end
      clear = r.clr_first && i == 0;
      cyc();
      t++;
      pulses += int'(err);
      if (!locked) dropped = 1;
    end
    clear = 0;
    if (r.clr_first) begin b0 = 0; e0 = 0; end
    if (r.exp_locked >= 0) chk("ph_locked", longint'(locked), r.exp_locked);
    if (r.exp_lat >= 0) chk("ph_lat", longint'(lat), r.exp_lat);
    if (r.exp_dbit >= 0) chk("ph_dbit", longint'(bit_ct) - b0, r.exp_dbit);
    if (r.exp_derr >= 0) chk("ph_derr", longint'(err_ct) - e0, r.exp_derr);
    if (r.exp_derr >= 0) chk("ph_pulses", pulses, r.exp_derr);
    if (r.exp_drop >= 0) chk("ph_drop", longint'(dropped), r.exp_drop);
  endtask

  initial begin
    //           delay cyc  pct mode clr lock lat dbit  derr drop
    rows[0] = '{10,  200, 100, 0, 0, 1,  9, -1,   0, -1};
    rows[1] = '{10,  1000, 100, 1, 0, 1, 9, 1000, 5,  0};
    rows[2] = '{10,  300, 100, 2, 0, 1,  9, -1,  -1,  1};
    rows[3] = '{10,  500, 70,  0, 0, 1,  9, -1,   0,  0};
    rows[4] = '{70,  5000, 100, 0, 1, 0, -1, 0,   0, -1};
    rows[5] = '{10,  400, 100, 0, 0, 1,  9, -1,   0, -1};
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_locked", longint'(locked), 0);
    chk("rst_lat", longint'(lat), 0);
    chk("rst_bit_ct", longint'(bit_ct), 0);
    chk("rst_err_ct", longint'(err_ct), 0);
    chk("rst_err_o", longint'(err), 0);
    @(posedge clk);
    #1;
    rst = 1;
    foreach (rows[i]) run_phase(rows[i]);
    // clear wins over a flipped, valid compare while locked
    tx_bit = 1'($urandom);
    tx_log[t] = tx_bit;
    rx_bit = ~tx_log[t - 10];
    rx_valid = 1;
    clear = 1;
    cyc();
    t++;
    clear = 0;
    chk("clr_bit_ct", longint'(bit_ct), 0);
    chk("clr_err_ct", longint'(err_ct), 0);
    chk("clr_err_o", longint'(err), 0);
    chk("clr_locked", longint'(locked), 0);
    run_phase('{10, 300, 100, 0, 0, 1, 9, -1, 0, -1});
    chk("ctw4_sat_bit", longint'(bit_ct4), 15);
    chk("ctw4_err", longint'(err_ct4), 0);
    // asynchronous reset between edges
    #3;
    rst = 0;
    #1;
    chk("arst_locked", longint'(locked), 0);
    chk("arst_lat", longint'(lat), 0);
    chk("arst_bit_ct", longint'(bit_ct), 0);
    chk("arst_err_ct", longint'(err_ct), 0);
    chk("arst_err_o", longint'(err), 0);
    chk("arst_bit_ct4", longint'(bit_ct4), 0);
    chk("arst_locked4", longint'(locked4), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    run_phase('{10, 300, 100, 0, 0, 1, 9, -1, 0, -1});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
